// File: rtl/video_pkg.sv
// Shared definitions for the video capture path: writer states and frame geometry defaults.
// No logic, no latency.
// No flow control.
package video_pkg;

    localparam int          IMAGE_WIDTH_DEF  = 640;
    localparam int          IMAGE_HEIGHT_DEF = 480;
    localparam logic [31:0] FRAME_BYTES      = 32'h0004B000;
    localparam int          BLOCK_SIZE_DEF   = 32;

    // Wishbone block writer states
    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_BLOCK,
        WRITE,
        ACK
    } wr_state_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous staging FIFO, DEPTH x WIDTH, head word visible combinationally.
// Push lands one cycle later; pop takes effect at the clock edge.
// A push while full is dropped unless a pop happens in the same cycle.
module word_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             p_clk,
    input  logic             p_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge p_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_in.sv
// Camera capture: packs 8-bit pixels into 32-bit LE words and block-writes them over Wishbone.
// Word pushed 1 cycle after its 4th pixel; CYC rises 1 cycle after a block is ready, STB 1 later.
// Slave stalls back up into the staging FIFO; pixels arriving with the FIFO full are dropped (sticky overflow).
module video_in
    import video_pkg::*;
#(
    parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
    parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
    parameter int BLOCK_SIZE   = BLOCK_SIZE_DEF,
    parameter int FIFO_WORDS   = 16
) (
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic        frame_valid,
    input  logic        line_valid,
    input  logic [7:0]  pixel_in,
    input  logic [31:0] frame_base,
    input  logic        base_valid,
    output logic        irq,
    output logic        overflow,
    input  logic [31:0] p_wb_DAT_I,
    output logic [31:0] p_wb_DAT_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I,
    input  logic        p_wb_RTY_I,
    output logic        p_wb_CYC_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_WE_O,
    output logic        p_wb_LOCK_O,
    output logic [3:0]  p_wb_SEL_O
);

    localparam int          CW          = $clog2(FIFO_WORDS) + 1;
    localparam logic [CW-1:0] BLOCK_WORDS = CW'(BLOCK_SIZE / 4);
    localparam logic [31:0] LAST_BYTE   = 32'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

    // Capture side
    logic        fv_q;
    logic        capture_en;
    logic [31:0] byte_cnt;
    logic [23:0] pack;
    logic        push_vld;
    logic [31:0] push_dat;
    logic        frame_start;
    logic        cap_done;

    // FIFO
    logic [31:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_pop;

    // Writer
    wr_state_t     state, nxt_state;
    logic [31:0]   address, nxt_address;
    logic [31:0]   dat, nxt_dat;
    logic [CW-1:0] rem, nxt_rem;
    logic          cyc, nxt_cyc;
    logic          stb, nxt_stb;
    logic          we, nxt_we;
    logic          nxt_irq;

    // Read data and the sub-block address bits carry no meaning for a write-only master
    logic unused_in;
    assign unused_in = ^{p_wb_DAT_I, frame_base[4:0]};

    // A frame is only armed when the writer is idle and has somewhere to put it
    assign frame_start = (state == WAIT_FRAME) && frame_valid && !fv_q && base_valid;
    // Capture is over only once the last completed word has actually reached the FIFO
    assign cap_done    = !capture_en && !push_vld;

    assign p_wb_ADR_O  = address;
    assign p_wb_DAT_O  = dat;
    assign p_wb_CYC_O  = cyc;
    assign p_wb_STB_O  = stb;
    assign p_wb_WE_O   = we;
    assign p_wb_LOCK_O = 1'b0;
    assign p_wb_SEL_O  = 4'hF;

    word_fifo #(
        .DEPTH (FIFO_WORDS),
        .WIDTH (32)
    ) u_fifo (
        .p_clk    (p_clk),
        .p_resetn (p_resetn),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Pixel sampling and little-endian packing; partial words at frame end are discarded
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            fv_q       <= 1'b0;
            capture_en <= 1'b0;
            byte_cnt   <= '0;
            pack       <= '0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
        end else begin
            fv_q     <= frame_valid;
            push_vld <= 1'b0;
            if (frame_start) begin
                capture_en <= 1'b1;
                byte_cnt   <= '0;
            end else if (capture_en) begin
                if (!frame_valid) begin
                    capture_en <= 1'b0;
                end else if (line_valid) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    case (byte_cnt[1:0])
                        2'd0: pack[7:0]   <= pixel_in;
                        2'd1: pack[15:8]  <= pixel_in;
                        2'd2: pack[23:16] <= pixel_in;
                        default: begin
                            push_vld <= 1'b1;
                            push_dat <= {pixel_in, pack};
                        end
                    endcase
                    if (byte_cnt == LAST_BYTE) begin
                        capture_en <= 1'b0;
                    end
                end
            end
        end
    end

    // Sticky drop flag; a pop in the same cycle frees the slot so the push survives
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            overflow <= 1'b0;
        end else if (push_vld && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // Writer state and registered bus outputs
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state   <= WAIT_FRAME;
            address <= '0;
            dat     <= '0;
            rem     <= '0;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            we      <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state   <= nxt_state;
            address <= nxt_address;
            dat     <= nxt_dat;
            rem     <= nxt_rem;
            cyc     <= nxt_cyc;
            stb     <= nxt_stb;
            we      <= nxt_we;
            irq     <= nxt_irq;
        end
    end

    // Writer next state; the FIFO head is popped as it is loaded into the data register
    always_comb begin
        nxt_state   = state;
        nxt_address = address;
        nxt_dat     = dat;
        nxt_rem     = rem;
        nxt_cyc     = cyc;
        nxt_stb     = stb;
        nxt_we      = we;
        nxt_irq     = 1'b0;
        fifo_pop    = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (frame_start) begin
                    nxt_address = {frame_base[31:5], 5'b0};
                    nxt_state   = WAIT_BLOCK;
                end
            end
            WAIT_BLOCK: begin
                if (fifo_count >= BLOCK_WORDS) begin
                    nxt_rem   = BLOCK_WORDS;
                    nxt_cyc   = 1'b1;
                    nxt_state = WRITE;
                end else if (cap_done && !fifo_empty) begin
                    nxt_rem   = fifo_count;
                    nxt_cyc   = 1'b1;
                    nxt_state = WRITE;
                end else if (cap_done) begin
                    nxt_irq   = 1'b1;
                    nxt_state = WAIT_FRAME;
                end
            end
            WRITE: begin
                nxt_dat   = fifo_head;
                fifo_pop  = 1'b1;
                nxt_stb   = 1'b1;
                nxt_we    = 1'b1;
                nxt_state = ACK;
            end
            ACK: begin
                // ERR still consumes the word so a faulty slave cannot stall the frame
                if (p_wb_ACK_I || p_wb_ERR_I) begin
                    nxt_address = address + 32'd4;
                    nxt_rem     = rem - 1'b1;
                    if (rem == CW'(1)) begin
                        nxt_cyc   = 1'b0;
                        nxt_stb   = 1'b0;
                        nxt_we    = 1'b0;
                        nxt_state = WAIT_BLOCK;
                    end else begin
                        nxt_dat  = fifo_head;
                        fifo_pop = 1'b1;
                    end
                end
                // RTY: hold address and data so the same word is offered again
            end
            default: nxt_state = WAIT_FRAME;
        endcase
    end

endmodule

// File: tb/tb_video_in.sv
// Directed bench for video_in with a small frame geometry and a configurable Wishbone slave.
module tb_video_in;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int FB = W * H;

    logic        p_clk;
    logic        p_resetn;
    logic        frame_valid;
    logic        line_valid;
    logic [7:0]  pixel_in;
    logic [31:0] frame_base;
    logic        base_valid;
    logic        irq;
    logic        overflow;
    logic [31:0] p_wb_DAT_I;
    logic [31:0] p_wb_DAT_O;
    logic [31:0] p_wb_ADR_O;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;
    logic        p_wb_RTY_I;
    logic        p_wb_CYC_O;
    logic        p_wb_STB_O;
    logic        p_wb_WE_O;
    logic        p_wb_LOCK_O;
    logic [3:0]  p_wb_SEL_O;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model controls (owned by the stimulus process)
    int   slave_wait;
    int   rty_word;
    logic clr;

    // Slave model state (owned by the posedge process)
    int   ack_total;
    int   wait_cnt;
    logic rty_done;

    // Monitor state (owned by the negedge process)
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int   cyc_cycles, bursts, irq_cnt, cyc_count, last_ack_cyc, irq_cyc, rty_seen;
    logic [31:0] rty_adr, rty_dat;
    logic cyc_q;

    video_in #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .BLOCK_SIZE   (32),
        .FIFO_WORDS   (16)
    ) dut (
        .p_clk       (p_clk),
        .p_resetn    (p_resetn),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .pixel_in    (pixel_in),
        .frame_base  (frame_base),
        .base_valid  (base_valid),
        .irq         (irq),
        .overflow    (overflow),
        .p_wb_DAT_I  (p_wb_DAT_I),
        .p_wb_DAT_O  (p_wb_DAT_O),
        .p_wb_ADR_O  (p_wb_ADR_O),
        .p_wb_ACK_I  (p_wb_ACK_I),
        .p_wb_ERR_I  (p_wb_ERR_I),
        .p_wb_RTY_I  (p_wb_RTY_I),
        .p_wb_CYC_O  (p_wb_CYC_O),
        .p_wb_STB_O  (p_wb_STB_O),
        .p_wb_WE_O   (p_wb_WE_O),
        .p_wb_LOCK_O (p_wb_LOCK_O),
        .p_wb_SEL_O  (p_wb_SEL_O)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    assign p_wb_DAT_I = 32'h0;
    assign p_wb_ERR_I = 1'b0;
    assign p_wb_RTY_I = p_wb_CYC_O && p_wb_STB_O && !rty_done && (ack_total == rty_word);
    assign p_wb_ACK_I = p_wb_CYC_O && p_wb_STB_O && !p_wb_RTY_I && (wait_cnt >= slave_wait);

    always @(posedge p_clk) begin
        if (clr) begin
            ack_total <= 0;
            wait_cnt  <= 0;
            rty_done  <= 1'b0;
        end else begin
            if (p_wb_RTY_I) rty_done <= 1'b1;
            if (p_wb_ACK_I) begin
                ack_total <= ack_total + 1;
                wait_cnt  <= 0;
            end else if (p_wb_CYC_O && p_wb_STB_O) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
            end
        end
    end

    always @(negedge p_clk) begin
        if (clr) begin
            wr_adr.delete();
            wr_dat.delete();
            cyc_cycles = 0; bursts = 0; irq_cnt = 0; cyc_count = 0;
            last_ack_cyc = 0; irq_cyc = 0; rty_seen = 0;
            rty_adr = '0; rty_dat = '0;
        end else begin
            cyc_count++;
            if (p_wb_CYC_O) cyc_cycles++;
            if (p_wb_CYC_O && !cyc_q) bursts++;
            if (p_wb_CYC_O && p_wb_STB_O && p_wb_ACK_I) begin
                wr_adr.push_back(p_wb_ADR_O);
                wr_dat.push_back(p_wb_DAT_O);
                last_ack_cyc = cyc_count;
            end
            if (p_wb_RTY_I) begin
                rty_seen++;
                rty_adr = p_wb_ADR_O;
                rty_dat = p_wb_DAT_O;
            end
            if (irq) begin
                irq_cnt++;
                irq_cyc = cyc_count;
            end
        end
        cyc_q = p_wb_CYC_O;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int k);
        return 8'((k * 7 + 3) & 255);
    endfunction

    function automatic logic [31:0] exp_word(input int i);
        return {pix(4*i+3), pix(4*i+2), pix(4*i+1), pix(4*i)};
    endfunction

    task automatic clear_stats();
        clr = 1'b1;
        @(posedge p_clk);
        @(posedge p_clk);
        clr = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge p_clk);
    endtask

    task automatic drive_frame(input logic [31:0] base, input logic bv, input int npix);
        @(negedge p_clk);
        frame_base  = base;
        base_valid  = bv;
        frame_valid = 1'b1;
        repeat (2) @(negedge p_clk);
        for (int k = 0; k < npix; k++) begin
            line_valid = 1'b1;
            pixel_in   = pix(k);
            @(negedge p_clk);
            if ((k % W) == W - 1) begin
                line_valid = 1'b0;
                repeat (2) @(negedge p_clk);
            end
        end
        line_valid = 1'b0;
        @(negedge p_clk);
        frame_valid = 1'b0;
        base_valid  = 1'b0;
        @(negedge p_clk);
    endtask

    task automatic wait_irq(input string tag, input int target, input int budget);
        for (int c = 0; c < budget && irq_cnt < target; c++) @(negedge p_clk);
        check(tag, irq_cnt, target);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] base, input int n);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= wr_adr.size()) errs++;
            else if (wr_adr[i] !== base + 32'(4*i) || wr_dat[i] !== exp_word(i)) errs++;
        end
        check(tag, errs, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        p_resetn = 1'b0; frame_valid = 1'b0; line_valid = 1'b0; pixel_in = '0;
        frame_base = '0; base_valid = 1'b0; slave_wait = 0; rty_word = -1; clr = 1'b0;
        repeat (3) @(negedge p_clk);

        check("rst_irq", irq, 0);
        check("rst_ovf", overflow, 0);
        check("rst_cyc", p_wb_CYC_O, 0);
        check("rst_stb", p_wb_STB_O, 0);
        check("rst_we", p_wb_WE_O, 0);
        check("rst_lock", p_wb_LOCK_O, 0);
        check("rst_sel", p_wb_SEL_O, 4'hF);
        check("rst_adr", p_wb_ADR_O, 32'h0);
        check("rst_dat", p_wb_DAT_O, 32'h0);

        p_resetn = 1'b1;
        clear_stats();

        // Full frame plus 8 extra pixels beyond the frame size limit
        drive_frame(32'h41000020, 1'b1, FB + 8);
        wait_irq("ff_irq_wait", 1, 3000);
        settle(20);
        check("ff_words", wr_adr.size(), FB / 4);
        check("ff_bursts", bursts, 4);
        check("ff_cyc_cycles", cyc_cycles, 36);
        check("ff_first_adr", wr_adr[0], 32'h41000020);
        check("ff_first_dat", wr_dat[0], 32'h18110A03);
        check("ff_last_adr", wr_adr[wr_adr.size()-1], 32'h4100009C);
        check_stream("ff_order", 32'h41000020, FB / 4);
        check("ff_irq_once", irq_cnt, 1);
        check("ff_ovf", overflow, 0);

        // Base address low bits are ignored
        clear_stats();
        drive_frame(32'h4100001F, 1'b1, 32);
        wait_irq("al_irq_wait", 1, 2000);
        settle(10);
        check("al_first_adr", wr_adr[0], 32'h41000000);
        check("al_words", wr_adr.size(), 8);

        // Short frame: 42 pixels give 10 words, trailing 2 pixels dropped
        clear_stats();
        drive_frame(32'h00002000, 1'b1, 42);
        wait_irq("sh_irq_wait", 1, 2000);
        settle(10);
        check("sh_words", wr_adr.size(), 10);
        check("sh_bursts", bursts, 2);
        check("sh_cyc_cycles", cyc_cycles, 12);
        check("sh_last_dat", wr_dat[wr_dat.size()-1], 32'h140D06FF);
        check("sh_last_adr", wr_adr[wr_adr.size()-1], 32'h00002024);
        check("sh_irq_delay", irq_cyc - last_ack_cyc, 2);
        check_stream("sh_order", 32'h00002000, 10);

        // Retry on the third word
        clear_stats();
        rty_word = 2;
        drive_frame(32'h00003000, 1'b1, 32);
        wait_irq("rt_irq_wait", 1, 2000);
        settle(10);
        rty_word = -1;
        check("rt_seen", rty_seen, 1);
        check("rt_adr", rty_adr, 32'h00003008);
        check("rt_dat", rty_dat, exp_word(2));
        check("rt_words", wr_adr.size(), 8);
        check_stream("rt_order", 32'h00003000, 8);

        // base_valid low: frame ignored
        clear_stats();
        drive_frame(32'h00006000, 1'b0, 32);
        settle(60);
        check("bv_words", wr_adr.size(), 0);
        check("bv_cyc", cyc_cycles, 0);
        check("bv_irq", irq_cnt, 0);

        // Second frame while writer busy is ignored
        clear_stats();
        slave_wait = 6;
        drive_frame(32'h00001000, 1'b1, 64);
        drive_frame(32'h00008000, 1'b1, 40);
        wait_irq("sf_irq_wait", 1, 3000);
        settle(200);
        check("sf_words", wr_adr.size(), 16);
        check("sf_irq", irq_cnt, 1);
        check("sf_last_adr", wr_adr[wr_adr.size()-1], 32'h0000103C);
        check_stream("sf_order", 32'h00001000, 16);

        // Slow slave on a full-rate frame overflows; then reset mid-burst
        clear_stats();
        slave_wait = 20;
        drive_frame(32'h00007000, 1'b1, FB);
        check("ov_flag", overflow, 1);
        for (int c = 0; c < 600 && !(p_wb_CYC_O && p_wb_STB_O); c++) @(negedge p_clk);
        check("ov_busy", p_wb_STB_O, 1);
        #2;
        p_resetn = 1'b0;
        #1;
        check("mr_cyc", p_wb_CYC_O, 0);
        check("mr_stb", p_wb_STB_O, 0);
        check("mr_we", p_wb_WE_O, 0);
        check("mr_irq", irq, 0);
        check("mr_ovf", overflow, 0);
        @(negedge p_clk);
        @(negedge p_clk);
        p_resetn = 1'b1;
        slave_wait = 0;
        clear_stats();
        drive_frame(32'h00005000, 1'b1, 32);
        wait_irq("mr_irq_wait", 1, 2000);
        settle(10);
        check("mr_first_adr", wr_adr[0], 32'h00005000);
        check("mr_first_dat", wr_dat[0], 32'h18110A03);
        check("mr_words", wr_adr.size(), 8);
        check("mr_ovf_after", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
